alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a registered result stage and an optional
// iterative shift-add multiplier.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-low reset
//   in_valid/in_ready         request handshake (op, src1, src2, in_tag)
//   out_valid/out_ready       response handshake (result, zero, ovf, err, out_tag)
//
// Configuration macro: ALU_PIPE_MUL_EN
//   defined   -> op 10 (MUL) runs on a DATA_W-cycle shift-add multiplier
//   undefined -> no multiplier hardware; op 10 is reported as illegal
module alu_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf,
  output logic              err,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned MSB  = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [TAG_W-1:0]    tag_q, tag_d;

`ifdef ALU_PIPE_MUL_EN
  logic [SH_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mul_next;
`endif

  logic [SH_W-1:0]     shamt;
  logic [DATA_W-1:0]   sum, diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf, alu_err, is_mul;
  logic                accept;

  // A new request is only taken when the output register is free or being drained.
  assign in_ready = rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle ALU operating on the live request inputs.
  always_comb begin
    shamt   = src2[SH_W-1:0];
    sum     = src1 + src2;
    diff    = src1 - src2;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (src1[MSB] == src2[MSB]) && (sum[MSB] != src1[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (src1[MSB] != src2[MSB]) && (diff[MSB] != src1[MSB]);
      end
      OP_SLL:  alu_res = src1 << shamt;
      OP_SLT:  alu_res = DATA_W'($signed(src1) < $signed(src2));
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_OR:   alu_res = src1 | src2;
      OP_AND:  alu_res = src1 & src2;
      OP_SRA:  alu_res = $signed(src1) >>> shamt;
      OP_SLTU: alu_res = DATA_W'(src1 < src2);
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  // One multiplier bit per cycle: add the shifted multiplicand when the current bit is set.
  assign mul_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    tag_d       = tag_q;
`ifdef ALU_PIPE_MUL_EN
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          tag_d = in_tag;
          if (is_mul) begin
            state_d     = MUL;
            out_valid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
            cnt_d       = '0;
            mcand_d     = src1;
            mplier_d    = src2;
            acc_d       = '0;
`endif
          end else begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            err_d       = alu_err;
          end
        end else if ((state_q == HOLD) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      MUL: begin
        acc_d    = mul_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(DATA_W - 1)) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          result_d    = mul_next;
          zero_d      = (mul_next == '0);
          ovf_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= '0;
`ifdef ALU_PIPE_MUL_EN
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
`ifdef ALU_PIPE_MUL_EN
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (DATA_W=32, TAG_W=4).
// A queue-based reference model tracks outstanding results; a negedge compare
// process checks handshakes and payloads every cycle. Honours ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic          zero, ovf, err;
  logic [3:0]    op;
  logic [TW-1:0] in_tag, out_tag;
  logic [DW-1:0] src1, src2, result;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic prev_rst = 1'b1;

  alu_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .err(err), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference ALU from the op definitions, using wide signed/unsigned arithmetic.
  function automatic exp_t alu_ref(input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] t);
    exp_t e;
    longint sa, sb, full;
    longint unsigned ua, ub;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = int'(b[4:0]);
    e.res = 32'd0; e.ovf = 1'b0; e.err = 1'b0; e.tag = t; e.rdy = 1;
    case (o)
      4'd0: begin full = sa + sb; e.res = 32'(full); e.ovf = (full > SMAX) || (full < SMIN); end
      4'd1: begin full = sa - sb; e.res = 32'(full); e.ovf = (full > SMAX) || (full < SMIN); end
      4'd2: e.res = 32'(ua << sh);
      4'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: e.res = a ^ b;
      4'd5: e.res = 32'(ua >> sh);
      4'd6: e.res = a | b;
      4'd7: e.res = a & b;
      4'd8: e.res = 32'(sa >>> sh);
      4'd9: e.res = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_PIPE_MUL_EN
      4'd10: begin e.res = 32'(ua * ub); e.rdy = DW + 1; end
`endif
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Per-cycle compare against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    logic exp_valid, exp_rdy;
    exp_t e;
    exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
    exp_rdy   = rst && ((q.size() == 0) || (exp_valid && out_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_valid)
      chk("payload", 64'({result, zero, ovf, err, out_tag}),
          64'({q[0].res, q[0].zero, q[0].ovf, q[0].err, q[0].tag}));
    if (!prev_rst)
      chk("after_reset", 64'({result, zero, ovf, err, out_tag}), 64'd0);
    if (!rst) q.delete();
    else begin
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        e = alu_ref(op, src1, src2, in_tag);
        e.rdy = cyc + e.rdy;
        q.push_back(e);
      end
    end
    prev_rst = rst;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op into an idle DUT, pin the model with literals, check latency and payload.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t, input logic [31:0] er,
                        input logic ez, input logic eo, input logic ee, input int el);
    exp_t m;
    int lat;
    m = alu_ref(o, a, b, t);
    chk({nm, "_model"}, 64'({m.res, m.zero, m.ovf, m.err}), 64'({er, ez, eo, ee}));
    in_valid = 1'b1; op = o; src1 = a; src2 = b; in_tag = t; out_ready = 1'b1;
    step();
    in_valid = 1'b0; op = 4'($urandom); src1 = $urandom; src2 = $urandom; in_tag = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(el));
    chk({nm, "_result"}, 64'({result, zero, ovf, err, out_tag}), 64'({er, ez, eo, ee, t}));
    step();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0;
    src1 = '0; src2 = '0; in_tag = '0;
    repeat (3) step();
    chk("reset_state", 64'({out_valid, in_ready, result, zero, ovf, err, out_tag}), 64'd0);
    rst = 1'b1;
    step();

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
    run_op("sra",     4'd8, 32'h8000_0000, 32'h0000_0024, 4'd2, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1);
    run_op("srl",     4'd5, 32'h8000_0000, 32'h0000_0024, 4'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1);
    run_op("slt",     4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
    run_op("sltu",    4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_zero",4'd1, 32'h0000_0005, 32'h0000_0005, 4'd7, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h0000_0001, 4'd8, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
    run_op("sll_max", 4'd2, 32'h0000_0001, 32'h0000_003F, 4'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1);
    run_op("illegal", 4'd15, 32'h1234_5678, 32'h0000_0001, 4'd10, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
`ifdef ALU_PIPE_MUL_EN
    run_op("mul",     4'd10, 32'h0001_0001, 32'h0001_0001, 4'd3, 32'h0002_0001, 1'b0, 1'b0, 1'b0, 33);
`else
    run_op("mul_off", 4'd10, 32'h0001_0001, 32'h0001_0001, 4'd3, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
`endif

    // Backpressure: first result held five cycles, drained together with a new request.
    in_valid = 1'b1; op = 4'd0; src1 = 32'd10; src2 = 32'd20; in_tag = 4'd5; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) begin
      chk("bp_hold", 64'({out_valid, result, out_tag}), 64'({1'b1, 32'd30, 4'd5}));
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; src1 = 32'h100; src2 = 32'h23; in_tag = 4'd6;
    step();
    in_valid = 1'b0;
    chk("bp_second", 64'({out_valid, result, out_tag}), 64'({1'b1, 32'h123, 4'd6}));
    step();

    // Reset in the middle of a multiply discards it.
    in_valid = 1'b1; op = 4'd10; src1 = 32'h0001_0001; src2 = 32'h0001_0001; in_tag = 4'd3;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_mul_reset", 64'({out_valid, result, zero, ovf, err, out_tag}), 64'd0);
    repeat (40) step();
    run_op("post_reset_add", 4'd0, 32'h0000_0001, 32'h0000_0002, 4'd11, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1);

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 4'($urandom_range(0, 15));
      src1      = pick();
      src2      = pick();
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
